// File: rtl/switch_debounce_sync.sv
// Synchronises and debounces a bank of switch/button lines for a PIO input port,
// with per-bit rise/fall pulses and an aggregate change strobe.
module switch_debounce_sync #(
  parameter int WIDTH        = 17,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change,
  output logic             ready
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  // ST_INIT waits for the synchroniser to fill, ST_RUN debounces forever.
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       init_cnt;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [PW-1:0]    presc;
  logic [CW-1:0]    cnt [WIDTH];
  logic             load_en;
  logic             run_en;
  logic             tick;
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] flip;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_cnt == 2'd2) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  always_comb begin
    load_en = (state == ST_INIT) && (init_cnt == 2'd2);
    run_en  = (state == ST_RUN);
    tick    = run_en && (presc == PRESC_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset)                 init_cnt <= 2'd0;
    else if (state == ST_INIT) init_cnt <= init_cnt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !run_en)      presc <= '0;
    else if (presc == PRESC_LAST) presc <= '0;
    else                       presc <= presc + PW'(1);
  end

  // A bit flips on the tick that completes its run of consecutive disagreeing ticks.
  always_comb begin
    differ = s2 ^ debounced_out;
    flip   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = tick && differ[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset)                        cnt[i] <= '0;
      else if (run_en) begin
        if (!differ[i] || flip[i])      cnt[i] <= '0;
        else if (tick)                  cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      debounced_out <= '0;
      rise_pulse    <= '0;
      fall_pulse    <= '0;
      any_change    <= 1'b0;
      ready         <= 1'b0;
    end else begin
      rise_pulse <= flip & s2;
      fall_pulse <= flip & ~s2;
      any_change <= |flip;
      if (load_en) begin
        debounced_out <= s2;
        ready         <= 1'b1;
      end else begin
        debounced_out <= debounced_out ^ flip;
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Bench for switch_debounce_sync: init table, directed debounce corner cases, and
// randomized switch activity compared every cycle against a reference model.
module tb_switch_debounce_sync;

  localparam int W  = 17;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] debounced_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic         any_change;
  logic         ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  switch_debounce_sync #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .debounced_out(debounced_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change),
    .ready(ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_tests++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, val, lo, hi, $time);
    end
  endtask

  // Reference model: sync is a two-sample delay, ticks fall on every TD-th edge after
  // entering run, and a bit flips once it has disagreed across ST consecutive ticks.
  logic [W-1:0] m_s1, m_s2, m_deb, m_rise, m_fall;
  logic         m_any, m_ready;
  int           m_init_edges, m_run_k;
  int           m_ticks [W];
  bit           mdl_valid = 1'b0;

  always @(posedge clk) begin : mdl
    bit tick;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_rise = '0; m_fall = '0;
      m_any = 1'b0; m_ready = 1'b0; m_init_edges = 0; m_run_k = 0;
      for (int i = 0; i < W; i++) m_ticks[i] = 0;
      mdl_valid = 1'b1;
    end else if (mdl_valid) begin
      m_rise = '0; m_fall = '0;
      if (!m_ready) begin
        if (m_init_edges == 2) begin
          m_deb   = m_s2;
          m_ready = 1'b1;
          m_run_k = 0;
        end
        m_init_edges++;
      end else begin
        m_run_k++;
        tick = (m_run_k % TD) == 0;
        for (int i = 0; i < W; i++) begin
          if (m_s2[i] == m_deb[i]) m_ticks[i] = 0;
          else if (tick) begin
            m_ticks[i]++;
            if (m_ticks[i] == ST) begin
              m_ticks[i] = 0;
              m_deb[i]   = m_s2[i];
              if (m_s2[i]) m_rise[i] = 1'b1;
              else         m_fall[i] = 1'b1;
            end
          end
        end
      end
      m_any = |(m_rise | m_fall);
      m_s2  = m_s1;
      m_s1  = sw_raw;
    end
    #1;
    if (mdl_valid)
      check("model", {debounced_out, rise_pulse, fall_pulse, any_change, ready},
            {m_deb, m_rise, m_fall, m_any, m_ready});
  end

  // Watches ncyc edges; reports the first debounced change and pulse activity.
  task automatic observe(input int ncyc, output int first_chg, output logic [W-1:0] chg_mask,
                         output logic [W-1:0] rp_cap, output logic [W-1:0] fp_cap,
                         output int n_any, output int n_pulse);
    logic [W-1:0] prev;
    prev = debounced_out;
    first_chg = -1; chg_mask = '0; rp_cap = '0; fp_cap = '0; n_any = 0; n_pulse = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk); #1;
      if (debounced_out !== prev && first_chg < 0) begin
        first_chg = i;
        chg_mask  = debounced_out ^ prev;
      end
      prev = debounced_out;
      if (any_change) begin
        if (n_any == 0) begin
          rp_cap = rise_pulse;
          fp_cap = fall_pulse;
        end
        n_any++;
      end
      n_pulse += $countones(rise_pulse) + $countones(fall_pulse);
    end
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] sw;
    logic [W-1:0] exp_deb;
    logic         exp_ready;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int           fc, na, np, tot_any, tot_chg;
    logic [W-1:0] cm, rp, fp;

    reset  = 1'b1;
    sw_raw = 17'h10001;

    // Init load: ready and the load land on the third edge after reset release.
    tbl[0] = '{1'b1, 17'h10001, 17'h00000, 1'b0};
    tbl[1] = '{1'b1, 17'h10001, 17'h00000, 1'b0};
    tbl[2] = '{1'b0, 17'h10001, 17'h00000, 1'b0};
    tbl[3] = '{1'b0, 17'h10001, 17'h00000, 1'b0};
    tbl[4] = '{1'b0, 17'h10001, 17'h10001, 1'b1};
    tbl[5] = '{1'b0, 17'h10001, 17'h10001, 1'b1};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      reset  = tbl[k].rst;
      sw_raw = tbl[k].sw;
      @(posedge clk); #1;
      check($sformatf("init_deb_%0d", k), debounced_out, tbl[k].exp_deb);
      check($sformatf("init_ready_%0d", k), ready, tbl[k].exp_ready);
      check($sformatf("init_pulses_%0d", k), {rise_pulse, fall_pulse, any_change}, '0);
    end

    // Clean press on bit 5.
    @(negedge clk); sw_raw[5] = 1'b1;
    observe(20, fc, cm, rp, fp, na, np);
    check("press_mask", cm, 17'h00020);
    check("press_rise", rp, 17'h00020);
    check("press_fall", fp, 17'h00000);
    check("press_any", na, 1);
    check_range("press_latency", fc - 2, 9, 12);

    // Release on bit 9: debounce the press, then the drop.
    @(negedge clk); sw_raw[9] = 1'b1;
    observe(20, fc, cm, rp, fp, na, np);
    check("hold9_rise", rp, 17'h00200);
    @(negedge clk); sw_raw[9] = 1'b0;
    observe(20, fc, cm, rp, fp, na, np);
    check("release_fall", fp, 17'h00200);
    check("release_rise", rp, 17'h00000);
    check("release_pulses", np, 1);
    check_range("release_latency", fc - 2, 9, 12);

    // Simultaneous rise on bit 3 and fall on bit 16.
    @(negedge clk); sw_raw[3] = 1'b1; sw_raw[16] = 1'b0;
    observe(20, fc, cm, rp, fp, na, np);
    check("simul_mask", cm, 17'h10008);
    check("simul_rise", rp, 17'h00008);
    check("simul_fall", fp, 17'h10000);
    check("simul_any", na, 1);
    check("simul_pulses", np, 2);

    // Bounce rejection on bit 0: first settle it at 0.
    @(negedge clk); sw_raw[0] = 1'b0;
    observe(20, fc, cm, rp, fp, na, np);
    check("bounce_prep_fall", fp, 17'h00001);
    tot_any = 0; tot_chg = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk); sw_raw[0] = ~sw_raw[0];
      observe(5, fc, cm, rp, fp, na, np);
      tot_any += na;
      if (fc >= 0) tot_chg++;
    end
    observe(20, fc, cm, rp, fp, na, np);
    tot_any += na;
    if (fc >= 0) tot_chg++;
    check("bounce0_any", tot_any, 0);
    check("bounce0_changes", tot_chg, 0);
    check("bounce0_level", debounced_out[0], 1'b0);

    // Bounce again, settling at 1.
    tot_any = 0; tot_chg = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); sw_raw[0] = ~sw_raw[0];
      observe(5, fc, cm, rp, fp, na, np);
      tot_any += na;
      if (fc >= 0) tot_chg++;
    end
    check("bounce1_quiet", tot_any + tot_chg, 0);
    @(negedge clk); sw_raw[0] = 1'b1;
    observe(20, fc, cm, rp, fp, na, np);
    check("bounce1_rise", rp, 17'h00001);
    check("bounce1_any", na, 1);
    check_range("bounce1_latency", fc - 2, 9, 12);

    // Reset while bit 7 is two ticks into its count.
    @(negedge clk); sw_raw[7] = 1'b1;
    observe(10, fc, cm, rp, fp, na, np);
    check("midcount_nochange", fc, -1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_outputs", {debounced_out, rise_pulse, fall_pulse, any_change, ready}, '0);
    @(negedge clk); reset = 1'b0;
    observe(2, fc, cm, rp, fp, na, np);
    check("reinit_not_ready", ready, 1'b0);
    observe(1, fc, cm, rp, fp, na, np);
    check("reinit_ready", ready, 1'b1);
    check("reinit_load", debounced_out, sw_raw);
    observe(20, fc, cm, rp, fp, na, np);
    check("reinit_no_pulses", na, 0);

    // Randomized activity: bouncy low bits, occasional random bit, rare reset.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 3) == 0) sw_raw[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) sw_raw[$urandom_range(0, W-1)] ^= 1'b1;
    end
    @(negedge clk); reset = 1'b0;
    repeat (20) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
